// File: rtl/ex_bypass_net.sv
// ex_bypass_net: execute-stage operand bypass for LANES issue lanes,
// with result history, load-pending scoreboard and stall counter.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module ex_bypass_net #(
   parameter int LANES = 2,
   parameter int DEPTH = 2,
   parameter int XLEN  = `DATA_WIDTH,
   parameter int RF_AW = `RF_ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES-1:0]       issue_valid,
   input  logic [LANES-1:0]       issue_rdwen,
   input  logic [LANES-1:0]       issue_ld,
   input  logic [LANES*RF_AW-1:0] issue_rdaddr,
   input  logic [LANES*RF_AW-1:0] issue_rs1addr,
   input  logic [LANES*RF_AW-1:0] issue_rs2addr,
   input  logic [LANES*XLEN-1:0]  rf_rs1,
   input  logic [LANES*XLEN-1:0]  rf_rs2,
   input  logic [LANES*XLEN-1:0]  ex_result,
   input  logic                   ld_ret_valid,
   input  logic [RF_AW-1:0]       ld_ret_rdaddr,
   input  logic [XLEN-1:0]        ld_ret_data,
   output logic [LANES*XLEN-1:0]  fwd_rs1,
   output logic [LANES*XLEN-1:0]  fwd_rs2,
   output logic                   stall,
   output logic [31:0]            stall_cnt
);

   localparam int NREG = 1 << RF_AW;

   logic [DEPTH-1:0][LANES-1:0]            hist_v;
   logic [DEPTH-1:0][LANES-1:0][RF_AW-1:0] hist_rd;
   logic [DEPTH-1:0][LANES-1:0][XLEN-1:0]  hist_d;
   logic [NREG-1:0]                        pending;
   logic [NREG-1:0]                        pend_eff;
   logic [NREG-1:0]                        pend_nxt;
   logic                                   advance;

   function automatic logic [RF_AW-1:0] rd_of(input int i);
      return issue_rdaddr[i*RF_AW +: RF_AW];
   endfunction

   function automatic logic [RF_AW-1:0] rs1_of(input int i);
      return issue_rs1addr[i*RF_AW +: RF_AW];
   endfunction

   function automatic logic [RF_AW-1:0] rs2_of(input int i);
      return issue_rs2addr[i*RF_AW +: RF_AW];
   endfunction

   // Lowest priority source is applied first; later hits override it.
   function automatic logic [XLEN-1:0] pick(
      input int              j,
      input logic [RF_AW-1:0] s,
      input logic [XLEN-1:0]  rf
   );
      logic [XLEN-1:0] v;
      v = rf;
      if (s != '0) begin
         for (int k = DEPTH-1; k >= 0; k--)
            for (int i = 0; i < LANES; i++)
               if (hist_v[k][i] && hist_rd[k][i] == s)
                  v = hist_d[k][i];
         if (ld_ret_valid && ld_ret_rdaddr == s)
            v = ld_ret_data;
         for (int i = 0; i < LANES; i++)
            if (i < j && issue_valid[i] && issue_rdwen[i] &&
                !issue_ld[i] && rd_of(i) == s)
               v = ex_result[i*XLEN +: XLEN];
      end
      return v;
   endfunction

   // Pending view with this cycle's load return already retired.
   always_comb begin
      pend_eff = pending;
      if (ld_ret_valid)
         pend_eff[ld_ret_rdaddr] = 1'b0;
   end

   // Final operand select per lane and source.
   always_comb begin
      fwd_rs1 = '0;
      fwd_rs2 = '0;
      for (int j = 0; j < LANES; j++) begin
         fwd_rs1[j*XLEN +: XLEN] = pick(j, rs1_of(j), rf_rs1[j*XLEN +: XLEN]);
         fwd_rs2[j*XLEN +: XLEN] = pick(j, rs2_of(j), rf_rs2[j*XLEN +: XLEN]);
      end
   end

   // Bundle stall from scoreboard and intra-bundle load hazards.
   always_comb begin
      stall = 1'b0;
      for (int j = 0; j < LANES; j++) begin
         if (issue_valid[j]) begin
            if (rs1_of(j) != '0 && pend_eff[rs1_of(j)])
               stall = 1'b1;
            if (rs2_of(j) != '0 && pend_eff[rs2_of(j)])
               stall = 1'b1;
            if (issue_rdwen[j] && pend_eff[rd_of(j)])
               stall = 1'b1;
            for (int i = 0; i < LANES; i++) begin
               if (i < j && issue_valid[i] && issue_rdwen[i] &&
                   rd_of(i) != '0) begin
                  if (issue_ld[i] &&
                      (rs1_of(j) == rd_of(i) || rs2_of(j) == rd_of(i)))
                     stall = 1'b1;
                  if (issue_rdwen[j] && rd_of(j) == rd_of(i) &&
                      (issue_ld[i] || issue_ld[j]))
                     stall = 1'b1;
               end
            end
         end
      end
   end

   assign advance = (|issue_valid) & ~stall;

   // Next scoreboard: retire returning load, then a new load re-sets.
   always_comb begin
      pend_nxt = pend_eff;
      for (int i = 0; i < LANES; i++)
         if (advance && issue_valid[i] && issue_rdwen[i] &&
             issue_ld[i] && rd_of(i) != '0)
            pend_nxt[rd_of(i)] = 1'b1;
   end

   // Result history shift register; stage 0 takes advancing ALU writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_v  <= '0;
         hist_rd <= '0;
         hist_d  <= '0;
      end else begin
         for (int k = DEPTH-1; k > 0; k--) begin
            hist_v[k]  <= hist_v[k-1];
            hist_rd[k] <= hist_rd[k-1];
            hist_d[k]  <= hist_d[k-1];
         end
         for (int i = 0; i < LANES; i++) begin
            hist_v[0][i]  <= advance & issue_valid[i] & issue_rdwen[i] &
                             ~issue_ld[i] & (rd_of(i) != '0);
            hist_rd[0][i] <= rd_of(i);
            hist_d[0][i]  <= ex_result[i*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard and saturating stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         stall_cnt <= '0;
      end else begin
         pending <= pend_nxt;
         if (stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_ex_bypass_net.sv
// tb_ex_bypass_net: directed bench for ex_bypass_net with
// hand-computed expectations (LANES=2, DEPTH=2, XLEN=32, RF_AW=5).
module tb_ex_bypass_net;

   localparam int L = 2;
   localparam int X = 32;
   localparam int A = 5;

   localparam logic [X-1:0] RF1_0 = 32'hA000_0000;
   localparam logic [X-1:0] RF1_1 = 32'hA000_0001;
   localparam logic [X-1:0] RF2_0 = 32'hB000_0000;
   localparam logic [X-1:0] RF2_1 = 32'hB000_0001;

   logic           clk = 1'b0;
   logic           rst;
   logic [L-1:0]   issue_valid, issue_rdwen, issue_ld;
   logic [L*A-1:0] issue_rdaddr, issue_rs1addr, issue_rs2addr;
   logic [L*X-1:0] rf_rs1, rf_rs2, ex_result;
   logic           ld_ret_valid;
   logic [A-1:0]   ld_ret_rdaddr;
   logic [X-1:0]   ld_ret_data;
   logic [L*X-1:0] fwd_rs1, fwd_rs2;
   logic           stall;
   logic [31:0]    stall_cnt;

   int checks = 0;
   int failures = 0;

   ex_bypass_net #(.LANES(L), .DEPTH(2), .XLEN(X), .RF_AW(A)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_rdwen(issue_rdwen),
      .issue_ld(issue_ld), .issue_rdaddr(issue_rdaddr),
      .issue_rs1addr(issue_rs1addr), .issue_rs2addr(issue_rs2addr),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .ex_result(ex_result),
      .ld_ret_valid(ld_ret_valid), .ld_ret_rdaddr(ld_ret_rdaddr),
      .ld_ret_data(ld_ret_data),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      issue_valid   = '0;
      issue_rdwen   = '0;
      issue_ld      = '0;
      issue_rdaddr  = '0;
      issue_rs1addr = '0;
      issue_rs2addr = '0;
      ex_result     = '0;
      ld_ret_valid  = 1'b0;
      ld_ret_rdaddr = '0;
      ld_ret_data   = '0;
   endtask

   task automatic lane(input int i, input logic v, input logic w,
                       input logic l, input int rd, input int r1,
                       input int r2, input logic [X-1:0] ex);
      issue_valid[i]            = v;
      issue_rdwen[i]            = w;
      issue_ld[i]               = l;
      issue_rdaddr[i*A +: A]    = 5'(rd);
      issue_rs1addr[i*A +: A]   = 5'(r1);
      issue_rs2addr[i*A +: A]   = 5'(r2);
      ex_result[i*X +: X]       = ex;
   endtask

   task automatic ret(input int rd, input logic [X-1:0] d);
      ld_ret_valid  = 1'b1;
      ld_ret_rdaddr = 5'(rd);
      ld_ret_data   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [X-1:0] f1(input int j);
      return fwd_rs1[j*X +: X];
   endfunction

   function automatic logic [X-1:0] f2(input int j);
      return fwd_rs2[j*X +: X];
   endfunction

   initial begin
      rst = 1'b1;
      clr();
      rf_rs1 = {RF1_1, RF1_0};
      rf_rs2 = {RF2_1, RF2_0};
      #2;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_fwd", f1(1), RF1_1);
      tick();
      rst = 1'b0;

      // intra-bundle forward
      clr();
      lane(0, 1, 1, 0, 5, 0, 0, 32'h11);
      lane(1, 1, 0, 0, 0, 5, 0, 0);
      #1;
      chk("intra_fwd", f1(1), 32'h11);
      chk("intra_stall", {31'd0, stall}, 32'd0);
      tick();

      // rd=x0 never forwards; x5 now sits in history stage 0
      clr();
      lane(0, 1, 1, 0, 0, 5, 0, 32'h22);
      lane(1, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("x0_rf", f1(1), RF1_1);
      chk("hist0_x5", f1(0), 32'h11);
      tick();
      clr();
      tick();
      tick();

      // history age-out
      clr();
      lane(0, 1, 1, 0, 7, 0, 0, 32'hAA);
      #1;
      tick();
      clr();
      lane(0, 1, 0, 0, 0, 7, 0, 0);
      #1;
      chk("age_t1", f1(0), 32'hAA);
      tick();
      #1;
      chk("age_t2", f1(0), 32'hAA);
      tick();
      #1;
      chk("age_t3", f1(0), RF1_0);
      tick();

      // load-use through scoreboard
      clr();
      lane(0, 1, 1, 1, 3, 0, 0, 0);
      #1;
      chk("ld_issue_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      lane(0, 1, 0, 0, 0, 3, 0, 0);
      #1;
      chk("ld_t1_stall", {31'd0, stall}, 32'd1);
      tick();
      #1;
      chk("ld_t2_stall", {31'd0, stall}, 32'd1);
      tick();
      ret(3, 32'hBEEF);
      #1;
      chk("ld_ret_stall", {31'd0, stall}, 32'd0);
      chk("ld_ret_fwd", f1(0), 32'hBEEF);
      tick();
      clr();
      lane(0, 1, 0, 0, 0, 3, 0, 0);
      #1;
      chk("ld_after_stall", {31'd0, stall}, 32'd0);
      chk("ld_after_rf", f1(0), RF1_0);
      chk("ld_cnt", stall_cnt, 32'd2);
      tick();

      // priority: intra > ld_ret > history stage 0 > stage 1
      clr();
      lane(0, 1, 1, 0, 9, 0, 0, 32'd2);
      tick();
      clr();
      lane(0, 1, 1, 0, 9, 0, 0, 32'hF0);
      lane(1, 1, 1, 0, 9, 0, 0, 32'd1);
      #1;
      chk("alu_waw_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      lane(0, 1, 1, 0, 9, 0, 0, 32'd3);
      lane(1, 1, 0, 0, 0, 9, 0, 0);
      #1;
      chk("prio_intra", f1(1), 32'd3);
      issue_valid[0] = 1'b0;
      #1;
      chk("prio_hist0", f1(1), 32'd1);
      ret(9, 32'h55);
      #1;
      chk("prio_ldret", f1(1), 32'h55);
      chk("prio_stall", {31'd0, stall}, 32'd0);
      tick();

      // intra-bundle load-use and load WAW
      clr();
      lane(0, 1, 1, 1, 4, 0, 0, 0);
      lane(1, 1, 0, 0, 0, 4, 0, 0);
      #1;
      chk("intra_ld_stall", {31'd0, stall}, 32'd1);
      tick();
      clr();
      lane(0, 1, 0, 0, 0, 4, 0, 0);
      #1;
      chk("intra_ld_nobit", {31'd0, stall}, 32'd0);
      chk("intra_ld_cnt", stall_cnt, 32'd3);
      tick();
      clr();
      lane(0, 1, 1, 1, 8, 0, 0, 0);
      lane(1, 1, 1, 0, 8, 0, 0, 32'h12);
      #1;
      chk("intra_waw_stall", {31'd0, stall}, 32'd1);
      tick();

      // scoreboard WAW, then async reset mid-stall
      clr();
      lane(0, 1, 1, 1, 6, 0, 0, 0);
      lane(1, 1, 1, 0, 10, 0, 0, 32'h77);
      #1;
      chk("h0_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      lane(0, 1, 1, 0, 6, 0, 0, 32'h99);
      lane(1, 1, 0, 0, 0, 10, 0, 0);
      #1;
      chk("sb_waw_stall", {31'd0, stall}, 32'd1);
      chk("pre_rst_hist", f1(1), 32'h77);
      chk("pre_rst_cnt", stall_cnt, 32'd4);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      chk("mid_rst_cnt", stall_cnt, 32'd0);
      chk("mid_rst_hist", f1(1), RF1_1);
      rst = 1'b0;
      clr();
      tick();

      // late return to a cleared bit still forwards
      clr();
      lane(0, 1, 0, 0, 0, 0, 6, 0);
      ret(6, 32'h66);
      #1;
      chk("late_ret_fwd", f2(0), 32'h66);
      chk("late_ret_stall", {31'd0, stall}, 32'd0);
      tick();
      clr();
      lane(0, 1, 0, 0, 0, 6, 6, 0);
      #1;
      chk("late_ret_nobit", {31'd0, stall}, 32'd0);
      chk("late_ret_rf", f2(0), RF2_0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
